mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Multi-cycle HI/LO multiply/divide unit. Sits beside the datapath ALU and consumes the same rs/rt operands.
//   Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO. Exposes HI/LO for MFHI/MFLO, plus a busy flag the controller uses to stall.
// PARAMETERS
//   MULT_LAT  5   edges from start sample to HI/LO write for MULT/MULTU (>=1)
//   WIDTH     32  operand width; HI/LO are WIDTH each
// PORTS
//   clk    in   1      single clock, rising edge
//   reset  in   1      asynchronous, active-high
//   start  in   1      op request, sampled on the rising edge
//   op     in   3      mdu_op_t: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (ignored)
//   a      in   WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source)
//   b      in   WIDTH  rt operand (divisor / multiplier)
//   busy   out  1      high while a MULT/DIV is in flight
//   done   out  1      one-cycle pulse in the cycle after HI/LO are written by MULT/DIV
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// BEHAVIOUR
//   Reset: hi=lo=0, busy=0, done=0, FSM=IDLE, all counters 0. Reset mid-operation aborts it; no result is written.
//   FSM states: IDLE, MUL, DIV, FIX.
//   IDLE + start + MULT/MULTU (edge E0):
//     - Latch the full 2*WIDTH product: signed for MULT, unsigned for MULTU. cnt=MULT_LAT-1. Go to MUL (or write now if MULT_LAT=1).
//     - MUL decrements cnt each edge. At edge E0+MULT_LAT: {hi,lo}=product, busy=0, done=1, return to IDLE.
//   IDLE + start + DIV/DIVU (E0):
//     - Latch |a| and |b| (raw values for DIVU), both sign bits, rem=0, cnt=WIDTH. Go to DIV.
//     - DIV: restoring shift-subtract, one quotient bit per edge, for edges E1..E32.
//     - FIX at E33: apply signs and write hi=remainder, lo=quotient, then done=1, IDLE. Latency 33 edges.
//     - Signed rule: quotient negated iff signs differ; remainder takes the dividend's sign.
//     - -2^31 / -1 (DIV): lo=32'h8000_0000, hi=0.
//     - Divisor 0 (DIV or DIVU): lo=32'hFFFF_FFFF, hi=a, same 33-edge latency.
//   IDLE + start + MTHI/MTLO: hi (or lo) = a at that edge. busy stays 0, done stays 0.
//   busy=1 from the edge after E0 through the write edge. It drops at the same edge that writes HI/LO.
//   start while busy: ignored entirely (no restart, no MTHI/MTLO). The controller must stall on busy.
//   hi/lo hold their old values throughout an operation and change only at the write edge.
//   Reserved op codes with start: no effect.
// STRUCTURE
//   Package mdu_pkg:
//     - mdu_op_t enum with the 3-bit codes above.
//     - FSM state enum.
//     - DIV_ITER=WIDTH localparam.
//   Sub-module mdu_divider: iterative unsigned restoring divider with start/busy/done handshake.
//     - Sign pre-processing, sign fixup, the multiply path and HI/LO live in the top.
// TESTING
//   1. MULT a=-3 (FFFFFFFD), b=7:
//      -> hi=FFFFFFFF, lo=FFFFFFEB exactly 5 edges after start; busy high 5 cycles; done 1 cycle.
//   2. MULTU a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE.
//      The same operands with MULT -> hi=FFFFFFFF, lo=FFFFFFFE.
//   3. DIV a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1) at edge E0+33.
//      DIVU a=100, b=7 -> lo=14, hi=2.
//   4. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//      DIVU a=1234, b=0 -> lo=FFFFFFFF, hi=1234.
//   5. MTHI a=CAFEBABE then MTLO a=12345678 on consecutive edges -> hi/lo update next edge, busy never asserts.
//      start+MTLO during a DIV -> ignored, lo unchanged.
//   6. Assert reset at E0+10 of a DIV:
//      -> hi=lo=0, busy=0 immediately (async), no done pulse.
//      A new MULT after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned DIV_ITER  = MDU_WIDTH;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock edge.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy_c,
    output logic             finish_c,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   trial_c;

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign trial_c   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    assign busy_c    = (cnt != '0);
    assign finish_c  = (cnt == CNT_W'(1));
    assign quotient  = quo;
    assign remainder = rem;

    // Load operands on start, then shift/subtract until the counter expires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (start && !busy_c) begin
            cnt <= CNT_W'(WIDTH);
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (busy_c) begin
            if (!trial_c[WIDTH]) begin
                rem <= trial_c[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO with busy stall flag.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned WIDTH    = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    mdu_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic               neg_q;
    logic               neg_r;
    logic               dvz;
    logic [WIDTH-1:0]   a_hold;

    mdu_op_t            op_c;
    logic               signed_c;
    logic               is_div_c;
    logic [2*WIDTH-1:0] ext_a_c;
    logic [2*WIDTH-1:0] ext_b_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   abs_a_c;
    logic [WIDTH-1:0]   abs_b_c;
    logic               div_start_c;
    logic               div_busy_c;
    logic               div_finish_c;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   quo_fix_c;
    logic [WIDTH-1:0]   rem_fix_c;

    // Operand decode, full-width product and divider sign pre-processing.
    always_comb begin
        op_c     = mdu_op_t'(op);
        signed_c = (op_c == OP_MULT) || (op_c == OP_DIV);
        is_div_c = (op_c == OP_DIV) || (op_c == OP_DIVU);
        ext_a_c  = signed_c ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b_c  = signed_c ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod_c   = ext_a_c * ext_b_c;
        abs_a_c  = (signed_c && a[WIDTH-1]) ? -a : a;
        abs_b_c  = (signed_c && b[WIDTH-1]) ? -b : b;
        div_start_c = (state == ST_IDLE) && start && is_div_c && !div_busy_c;
        quo_fix_c = neg_q ? -div_quo : div_quo;
        rem_fix_c = neg_r ? -div_rem : div_rem;
    end

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_c),
        .dividend  (abs_a_c),
        .divisor   (abs_b_c),
        .busy_c    (div_busy_c),
        .finish_c  (div_finish_c),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Control FSM plus HI/LO, busy and done registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            prod   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvz    <= 1'b0;
            a_hold <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op_c)
                            OP_MULT, OP_MULTU: begin
                                if (MULT_LAT <= 1) begin
                                    {hi, lo} <= prod_c;
                                    done     <= 1'b1;
                                end else begin
                                    prod  <= prod_c;
                                    cnt   <= CNT_W'(MULT_LAT - 1);
                                    busy  <= 1'b1;
                                    state <= ST_MUL;
                                end
                            end
                            OP_DIV, OP_DIVU: begin
                                neg_q  <= signed_c && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r  <= signed_c && a[WIDTH-1];
                                dvz    <= (b == '0);
                                a_hold <= a;
                                busy   <= 1'b1;
                                state  <= ST_DIV;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= prod;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (div_finish_c) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi    <= dvz ? a_hold : rem_fix_c;
                    lo    <= dvz ? '1 : quo_fix_c;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
